fir_mac_sched: RTL and testbench
================================

// Module: fir_mac_sched
// PURPOSE
//  Time-multiplexed FIR controller: shares one mult12x12 instance across NTAPS taps.
//  Per accepted input sample it computes y[n] = sum_k h[k]*x[n-k] over NTAPS MAC cycles
//  and presents y[n] on a valid/ready output.
//  Owns the sample delay line (circular buffer) and the coefficient register file.
//  Sits between the sample source (ADC/stream side) and downstream filter consumers.
// PARAMETERS
//  NTAPS  16                    number of taps; power of 2, 2..64
//  DW     12                    sample/coefficient width; fixed by the mult12x12 datapath
//  ACC_W  2*DW+$clog2(NTAPS)    accumulator/output width (28 at defaults); sized so no overflow
// PORTS
//  Clk         in   1          single clock, rising edge
//  Rst_n       in   1          asynchronous, active-low reset
//  In_Valid    in   1          input sample valid
//  In_Ready    out  1          block can accept a sample
//  In_Data     in   DW         signed two's-complement sample x[n]
//  Coef_We     in   1          coefficient write strobe
//  Coef_Addr   in   log2(NTAPS) tap index k
//  Coef_Wdata  in   DW         signed coefficient h[k]
//  Coef_Err    out  1          1-cycle pulse: write dropped because Busy
//  Out_Valid   out  1          y[n] valid; held until accepted
//  Out_Ready   in   1          downstream accepts y[n]
//  Out_Data    out  ACC_W      signed y[n]; stable while Out_Valid=1
//  Busy        out  1          1 in MAC or OUT state
// BEHAVIOUR
//  Reset (Rst_n=0, async): state=IDLE, In_Ready=0 during reset, Out_Valid=0, Out_Data=0,
//   Coef_Err=0, Busy=0, all coefficients=0, delay line=0, wr_ptr=0, tap_cnt=0, acc=0.
//   Reset mid-operation aborts the computation; no partial result is ever output.
//  FSM: IDLE -> MAC on In_Valid&In_Ready; MAC -> OUT after NTAPS MAC cycles;
//   OUT -> IDLE on Out_Valid&Out_Ready.
//  In_Ready = (state==IDLE). Sample accepted at edge T0: x written at wr_ptr, acc cleared,
//   tap_cnt=0, rd base = wr_ptr.
//  MAC cycle k (k=0..NTAPS-1): Din = dline[(base-k) mod NTAPS], Coeff = coef[k];
//   acc <= acc + sext(Product, ACC_W). Pointer arithmetic wraps modulo NTAPS (natural wrap).
//  After last MAC cycle: Out_Data <= acc, Out_Valid=1 in OUT. Latency: Out_Valid high
//   NTAPS+1 edges after the accept edge (T0+17 at defaults).
//  wr_ptr increments (wraps NTAPS-1 -> 0) once per accepted sample.
//  OUT: Out_Data/Out_Valid held under backpressure; In_Ready=0; no same-cycle accept on
//   exit. In_Ready rises the cycle after the output handshake.
//  Coefficient writes: applied on the edge when Coef_We=1 and Busy=0; when Busy=1 the write
//   is dropped and Coef_Err pulses the next cycle. Coef_We and an input accept in the same
//   IDLE cycle: write applies first; the following MAC uses the new value.
//  Arithmetic: all signed; -2048*-2048 = +2^22 fits the 24-bit Product; NTAPS worst-case
//   sum fits ACC_W; no saturation or rounding.
// STRUCTURE
//  fir_pkg: DW, default NTAPS, ACC_W function, typedef enum logic [1:0] {IDLE,MAC,OUT} fir_state_t.
//  Sub-module: one mult12x12 instance (Din, Coeff, Product), used combinationally each MAC
//   cycle. Delay line, coefficient file, counters, and FSM live in this module.
// TESTING
//  1 Impulse: h[k]=k+1, feed 1 then 0s -> y = 1,2,3,...,16, then 0.
//  2 Sign/extremes: all h=-2048, x=-2048 steady -> after 16 samples y = 16*2^22 = 67108864;
//    all h=2047, x=-2048 -> y = -67076096.
//  3 Backpressure: Out_Ready=0 for 10 cycles -> Out_Data stable, In_Ready=0, In_Valid ignored.
//  4 Latency/wrap: 40 samples back-to-back, Out_Ready=1 -> each Out_Valid at accept+17;
//    results match a golden model across wr_ptr wrap.
//  5 Coef write during MAC -> Coef_Err pulse, coef unchanged; same write in IDLE applies.
//  6 Assert Rst_n low at MAC cycle 7 -> all outputs 0 immediately; after release,
//    impulse test reproduces with zeroed history.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the time-multiplexed FIR MAC scheduler.
// The datapath width is fixed by the single shared 12x12 multiplier.
package fir_pkg;

  localparam int DW        = 12;
  localparam int NTAPS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  // Accumulator width: full product plus log2(NTAPS) guard bits, so the sum cannot overflow.
  function automatic int fir_acc_w(input int ntaps);
    return 2 * DW + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/mult12x12.sv
// Signed 12x12 combinational multiplier shared by every tap of the FIR.
// The full 24-bit product is kept, so -2048 * -2048 = +2^22 is representable.
module mult12x12 (
  input  logic signed [11:0] Din,
  input  logic signed [11:0] Coeff,
  output logic signed [23:0] Product
);

  assign Product = Din * Coeff;

endmodule

// File: rtl/fir_mac_sched.sv
// FIR controller: one multiplier is reused across NTAPS MAC cycles per accepted sample.
// Holds the circular sample delay line, the coefficient file and the IDLE/MAC/OUT sequencer.
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int ACC_W = fir_acc_w(NTAPS)
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      In_Valid,
  output logic                      In_Ready,
  input  logic signed [DW-1:0]      In_Data,
  input  logic                      Coef_We,
  input  logic [$clog2(NTAPS)-1:0]  Coef_Addr,
  input  logic signed [DW-1:0]      Coef_Wdata,
  output logic                      Coef_Err,
  output logic                      Out_Valid,
  input  logic                      Out_Ready,
  output logic signed [ACC_W-1:0]   Out_Data,
  output logic                      Busy
);

  localparam int AW = $clog2(NTAPS);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_MAC  = MAC;
  localparam logic [1:0] ST_OUT  = OUT;

  logic [1:0]              state;
  logic                    live;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           base;
  logic [AW:0]             tap_cnt;
  logic signed [ACC_W-1:0] acc;

  logic signed [DW-1:0]    coef  [NTAPS];
  logic signed [DW-1:0]    dline [NTAPS];

  logic [AW-1:0]           tap_idx;
  logic [AW-1:0]           rd_idx;
  logic signed [DW-1:0]    din;
  logic signed [DW-1:0]    coeff;
  logic signed [2*DW-1:0]  product;
  logic signed [ACC_W-1:0] product_ext;
  logic                    accept;
  logic                    last_done;
  logic                    coef_wr;

  // live keeps In_Ready low while reset is asserted and for the first edge after release.
  assign In_Ready  = live && (state == ST_IDLE);
  assign Busy      = (state != ST_IDLE);
  assign Out_Valid = (state == ST_OUT);
  assign accept    = In_Valid && In_Ready;
  assign coef_wr   = Coef_We && !Busy;

  // tap_cnt carries one extra bit: reaching NTAPS marks the cycle that publishes acc.
  assign tap_idx     = tap_cnt[AW-1:0];
  assign last_done   = tap_cnt[AW];
  assign rd_idx      = base - tap_idx;
  assign din         = dline[rd_idx];
  assign coeff       = coef[tap_idx];
  assign product_ext = {{(ACC_W-2*DW){product[2*DW-1]}}, product};

  mult12x12 u_mult (
    .Din     (din),
    .Coeff   (coeff),
    .Product (product)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      live     <= 1'b0;
      wr_ptr   <= '0;
      base     <= '0;
      tap_cnt  <= '0;
      acc      <= '0;
      Out_Data <= '0;
      Coef_Err <= 1'b0;
    end else begin
      live     <= 1'b1;
      Coef_Err <= Coef_We && Busy;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_MAC;
            base    <= wr_ptr;
            wr_ptr  <= wr_ptr + 1'b1;
            tap_cnt <= '0;
            acc     <= '0;
          end
        end
        ST_MAC: begin
          if (last_done) begin
            Out_Data <= acc;
            state    <= ST_OUT;
          end else begin
            acc     <= acc + product_ext;
            tap_cnt <= tap_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (Out_Ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: both arrays are reset because a reset must leave zeroed history and coefficients.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef[i]  <= '0;
        dline[i] <= '0;
      end
    end else begin
      if (coef_wr) coef[Coef_Addr] <= Coef_Wdata;
      if (accept)  dline[wr_ptr]   <= In_Data;
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched: directed sequence with random data,
// checked against a sum-of-products model over a queue of past samples.
module tb_fir_mac_sched;
  import fir_pkg::*;

  localparam int NTAPS = 16;
  localparam int ACC_W = 2 * DW + $clog2(NTAPS);
  localparam int AW    = $clog2(NTAPS);

  logic                     Clk;
  logic                     Rst_n;
  logic                     In_Valid;
  logic                     In_Ready;
  logic signed [DW-1:0]     In_Data;
  logic                     Coef_We;
  logic [AW-1:0]            Coef_Addr;
  logic signed [DW-1:0]     Coef_Wdata;
  logic                     Coef_Err;
  logic                     Out_Valid;
  logic                     Out_Ready;
  logic signed [ACC_W-1:0]  Out_Data;
  logic                     Busy;

  fir_mac_sched #(.NTAPS(NTAPS)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .In_Data    (In_Data),
    .Coef_We    (Coef_We),
    .Coef_Addr  (Coef_Addr),
    .Coef_Wdata (Coef_Wdata),
    .Coef_Err   (Coef_Err),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Data   (Out_Data),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     acc_cyc  = 0;
  longint h [NTAPS];
  longint hist [$];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // y[n] = sum_k h[k] * x[n-k], with samples older than the history taken as zero.
  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < NTAPS; k++)
      if (k < hist.size()) s += h[k] * hist[k];
    return s;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < NTAPS; k++) h[k] = 0;
  endtask

  task automatic write_coef(input int addr, input int val);
    Coef_We    = 1'b1;
    Coef_Addr  = addr[AW-1:0];
    Coef_Wdata = val[DW-1:0];
    tick();
    Coef_We = 1'b0;
    h[addr] = val;
    check("coef_err_idle", Coef_Err, 0);
  endtask

  task automatic accept_sample(input int x, output longint y);
    int guard = 0;
    while (!In_Ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_wait", In_Ready, 1);
    In_Valid = 1'b1;
    In_Data  = x[DW-1:0];
    tick();
    In_Valid = 1'b0;
    acc_cyc  = cyc;
    hist.push_front(x);
    if (hist.size() > NTAPS) void'(hist.pop_back());
    y = model_y();
  endtask

  task automatic finish_sample(input longint y, input int hold, input string tag);
    int guard = 0;
    logic signed [ACC_W-1:0] held;
    while (!Out_Valid && guard < 100) begin
      tick();
      guard++;
    end
    check("latency", cyc - acc_cyc, NTAPS + 1);
    check(tag, Out_Data, y);
    held = Out_Data;
    for (int i = 0; i < hold; i++) begin
      In_Valid = 1'b1;
      In_Data  = DW'($urandom);
      tick();
      check("bp_data_stable", Out_Data, held);
      check("bp_valid_held", Out_Valid, 1);
      check("bp_in_ready_low", In_Ready, 0);
    end
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    check("out_valid_drop", Out_Valid, 0);
    check("in_ready_after_hs", In_Ready, 1);
  endtask

  task automatic run_sample(input int x, input string tag);
    longint y;
    accept_sample(x, y);
    finish_sample(y, 0, tag);
  endtask

  task automatic reset_release();
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint y;
    int x;

    Rst_n = 1'b0; In_Valid = 1'b0; In_Data = '0; Coef_We = 1'b0;
    Coef_Addr = '0; Coef_Wdata = '0; Out_Ready = 1'b0;
    model_clear();

    // Reset state
    tick();
    check("rst_in_ready", In_Ready, 0);
    check("rst_out_valid", Out_Valid, 0);
    check("rst_out_data", Out_Data, 0);
    check("rst_coef_err", Coef_Err, 0);
    check("rst_busy", Busy, 0);
    reset_release();

    // Impulse: h[k]=k+1, x = 1,0,0,... -> y = 1..16 then 0
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    run_sample(1, "impulse");
    check("impulse_first", Out_Data, 1);
    for (int i = 1; i <= NTAPS; i++) run_sample(0, "impulse");
    check("impulse_tail", Out_Data, 0);

    // Sign extremes
    for (int k = 0; k < NTAPS; k++) write_coef(k, -2048);
    for (int i = 0; i < NTAPS; i++) run_sample(-2048, "neg_neg");
    check("neg_neg_full", Out_Data, 67108864);
    for (int k = 0; k < NTAPS; k++) write_coef(k, 2047);
    for (int i = 0; i < NTAPS; i++) run_sample(-2048, "pos_neg");
    check("pos_neg_full", Out_Data, -67076096);

    // Backpressure: 10 stalled cycles with In_Valid asserted
    accept_sample(1234, y);
    finish_sample(y, 10, "bp_result");
    run_sample(-7, "after_bp");

    // Random coefficients and 40 back-to-back samples across wr_ptr wrap
    for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(4095)) - 2048);
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(4095)) - 2048;
      run_sample(x, "random");
    end

    // Coefficient write while busy is dropped and flagged
    accept_sample(100, y);
    tick(); tick(); tick();
    Coef_We = 1'b1; Coef_Addr = '0; Coef_Wdata = 12'sd777;
    tick();
    Coef_We = 1'b0;
    check("coef_err_pulse", Coef_Err, 1);
    tick();
    check("coef_err_clear", Coef_Err, 0);
    finish_sample(y, 0, "coef_drop");
    write_coef(0, 777);
    run_sample(5, "coef_applied");

    // Write and accept in the same IDLE cycle: new coefficient is used
    Coef_We = 1'b1; Coef_Addr = '0; Coef_Wdata = -12'sd300;
    h[0] = -300;
    accept_sample(9, y);
    Coef_We = 1'b0;
    check("coef_same_cycle_err", Coef_Err, 0);
    finish_sample(y, 0, "coef_same_cycle");

    // Reset in the middle of MAC aborts the computation
    accept_sample(321, y);
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", Busy, 1);
    Rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", Out_Valid, 0);
    check("mid_rst_out_data", Out_Data, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_in_ready", In_Ready, 0);
    check("mid_rst_coef_err", Coef_Err, 0);
    model_clear();
    reset_release();
    check("post_rst_no_output", Out_Valid, 0);
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    run_sample(1, "impulse2");
    for (int i = 1; i <= NTAPS; i++) run_sample(0, "impulse2");
    check("impulse2_tail", Out_Data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
